// File: rtl/fp_align_shiftright.sv
// Two-stage right-shift aligner: 25-bit mantissa with guard/round/sticky capture
// and exponent adjust, valid/ready handshake on both sides.
module fp_align_shiftright (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [24:0] in_mant,
  input  logic [5:0]  in_nshift,
  input  logic [7:0]  in_exp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [24:0] out_mant,
  output logic        out_guard,
  output logic        out_round,
  output logic        out_sticky,
  output logic [8:0]  out_exp
);

  logic        r_v1;
  logic        r_v2;
  logic [26:0] r_ext1;
  logic [26:0] r_ext2;
  logic        r_sticky1;
  logic        r_sticky2;
  logic [2:0]  r_fine1;
  logic [8:0]  r_exp1;
  logic [8:0]  r_exp2;

  logic        w_load1;
  logic        w_load2;
  logic [5:0]  w_coarseAmt;
  logic [82:0] w_coarse;
  logic [33:0] w_fine;

  assign w_load2  = !r_v2 || out_ready;
  assign w_load1  = !r_v1 || w_load2;
  assign in_ready = w_load1;

  // Widened words keep every shifted-out bit visible so the sticky OR sees all of them.
  assign w_coarseAmt = {in_nshift[5:3], 3'b000};
  assign w_coarse    = {in_mant, 2'b00, 56'd0} >> w_coarseAmt;
  assign w_fine      = {r_ext1, 7'd0} >> r_fine1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      if (w_load1) r_v1 <= in_valid;
      if (w_load2) r_v2 <= r_v1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_load1 && in_valid) begin
      r_ext1    <= w_coarse[82:56];
      r_sticky1 <= |w_coarse[55:0];
      r_fine1   <= in_nshift[2:0];
      r_exp1    <= {1'b0, in_exp} + {3'b000, in_nshift};
    end
    if (w_load2 && r_v1) begin
      r_ext2    <= w_fine[33:7];
      r_sticky2 <= r_sticky1 | (|w_fine[6:0]);
      r_exp2    <= r_exp1;
    end
  end

  // Data registers carry no reset; gating on the valid flag forces zeros during reset.
  assign out_valid  = r_v2;
  assign out_mant   = r_v2 ? r_ext2[26:2] : 25'd0;
  assign out_guard  = r_v2 & r_ext2[1];
  assign out_round  = r_v2 & r_ext2[0];
  assign out_sticky = r_v2 & r_sticky2;
  assign out_exp    = r_v2 ? r_exp2 : 9'd0;

endmodule

// File: tb/tb_fp_align_shiftright.sv
// Scoreboard bench for fp_align_shiftright: random and directed operands checked
// against an arithmetic shift model, with backpressure and mid-flight reset.
module tb_fp_align_shiftright;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [24:0] in_mant = '0;
  logic [5:0]  in_nshift = '0;
  logic [7:0]  in_exp = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [24:0] out_mant;
  logic        out_guard;
  logic        out_round;
  logic        out_sticky;
  logic [8:0]  out_exp;

  typedef struct packed {
    logic [24:0] mant;
    logic        g;
    logic        r;
    logic        s;
    logic [8:0]  exp;
  } res_t;

  res_t sbQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;

  fp_align_shiftright dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_nshift(in_nshift), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_guard(out_guard), .out_round(out_round),
    .out_sticky(out_sticky), .out_exp(out_exp)
  );

  always #5 clk = ~clk;

  // Reference: treat {mant,00} as an integer, shift it, and OR whatever fell off.
  function automatic res_t refModel(input logic [24:0] m, input logic [5:0] n, input logic [7:0] e);
    longint unsigned ext, kept, lost;
    res_t r;
    ext  = longint'(m) * 4;
    kept = ext >> n;
    lost = ext & ((64'd1 << n) - 64'd1);
    r.mant = kept[26:2];
    r.g    = kept[1];
    r.r    = kept[0];
    r.s    = (lost != 0);
    r.exp  = 9'(e) + 9'(n);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    testsRun++;
    if (act !== expv) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Drives one cycle of stimulus; pushes the expected result if the operand is taken.
  task automatic applyStimulus(input logic v, input logic [24:0] m, input logic [5:0] n,
                               input logic [7:0] e, input logic ordy, output logic taken);
    in_valid  = v;
    in_mant   = m;
    in_nshift = n;
    in_exp    = e;
    out_ready = ordy;
    @(negedge clk);
    checkOutput("in_ready", 64'(in_ready), 64'(!(sbQ.size() == 2 && !ordy)));
    taken = v && in_ready;
    if (taken) sbQ.push_back(refModel(m, n, e));
    @(posedge clk);
    #1;
  endtask

  // Monitor pops one expected result per output transfer and checks stall stability.
  res_t held;
  logic stallActive = 1'b0;
  always begin
    res_t cur;
    res_t expr;
    @(negedge clk);
    #1;
    cur = {out_mant, out_guard, out_round, out_sticky, out_exp};
    if (rst_n && out_valid) begin
      if (stallActive) checkOutput("stall_hold", 64'(cur), 64'(held));
      if (out_ready) begin
        stallActive = 1'b0;
        if (sbQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected_output: got %0h expected no output", cur);
        end else begin
          expr = sbQ.pop_front();
          checkOutput("result", 64'(cur), 64'(expr));
        end
      end else begin
        held = cur;
        stallActive = 1'b1;
      end
    end else begin
      stallActive = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct packed {
    logic [24:0] m;
    logic [5:0]  n;
    logic [7:0]  e;
  } op_t;

  initial begin
    logic taken;
    op_t  dirOps[$];
    int   idx;
    int   budget;

    // Outputs in reset
    #3;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_outputs", 64'({out_mant, out_guard, out_round, out_sticky, out_exp}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed boundary operands, back to back with out_ready high
    dirOps = '{'{25'h1000000, 6'd1, 8'h10}, '{25'h1000000, 6'd25, 8'h20},
               '{25'h1000000, 6'd26, 8'h30}, '{25'h1000000, 6'd27, 8'h40},
               '{25'h0000007, 6'd3, 8'h01}, '{25'h0000007, 6'd63, 8'h02},
               '{25'h0000000, 6'd63, 8'h03}, '{25'h1ABCDEF, 6'd0, 8'h04},
               '{25'h1FFFFFF, 6'd63, 8'hFF}, '{25'h0000003, 6'd24, 8'h7F}};
    foreach (dirOps[i]) applyStimulus(1'b1, dirOps[i].m, dirOps[i].n, dirOps[i].e, 1'b1, taken);

    // Two-cycle latency on an idle pipeline
    repeat (4) applyStimulus(1'b0, '0, '0, '0, 1'b1, taken);
    applyStimulus(1'b1, 25'h0ABCDE, 6'd5, 8'h11, 1'b1, taken);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("latency_c1", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("latency_c2", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;

    // Eight operands with out_ready toggling 1,0,0,1,...
    idx = 0;
    budget = 0;
    while (idx < 8 && budget < 100) begin
      applyStimulus(1'b1, 25'(idx * 25'h0123457), 6'(idx * 5), 8'(idx), (budget % 3) == 0, taken);
      if (taken) idx++;
      budget++;
    end
    checkOutput("toggle_all_taken", 64'(idx), 64'd8);

    // Random traffic with random backpressure
    for (int k = 0; k < 600; k++) begin
      logic [24:0] m;
      logic [5:0]  n;
      m = ($urandom_range(0, 3) == 0) ? 25'($urandom_range(0, 15)) : 25'($urandom);
      n = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(23, 28)) : 6'($urandom_range(0, 63));
      applyStimulus($urandom_range(0, 3) != 0, m, n, 8'($urandom), $urandom_range(0, 2) != 0, taken);
    end

    // Fill the pipeline, then reset asynchronously mid-cycle
    repeat (6) applyStimulus(1'b0, '0, '0, '0, 1'b1, taken);
    applyStimulus(1'b1, 25'h1555555, 6'd2, 8'h21, 1'b0, taken);
    applyStimulus(1'b1, 25'h0AAAAAA, 6'd9, 8'h22, 1'b0, taken);
    applyStimulus(1'b1, 25'h1234567, 6'd1, 8'h23, 1'b0, taken);
    checkOutput("full_blocks_input", 64'(taken), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("async_rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("async_rst_outputs", 64'({out_mant, out_guard, out_round, out_sticky, out_exp}), 64'd0);
    sbQ.delete();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) applyStimulus(1'b0, '0, '0, '0, 1'b1, taken);
    applyStimulus(1'b1, 25'h0F0F0F0, 6'd4, 8'h99, 1'b1, taken);
    checkOutput("accept_after_reset", 64'(taken), 64'd1);

    // Drain
    budget = 0;
    while (sbQ.size() != 0 && budget < 20) begin
      applyStimulus(1'b0, '0, '0, '0, 1'b1, taken);
      budget++;
    end
    repeat (2) applyStimulus(1'b0, '0, '0, '0, 1'b1, taken);
    checkOutput("drain_empty", 64'(sbQ.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
